hicore_wb_arbiter: RTL and testbench
====================================

// Module: hicore_wb_arbiter
// PURPOSE
//  Merges write-back results from NUM_SRC execution units (nop/mret/fence.i, ALU, LSU, MDU ...) onto the single
//  registered ROB write-back port. Per-source buffer absorbs non-backpressurable wen pulses; fair round-robin
//  selection; stall per source fed back to the issue stage to gate its ready. Sits between the FUs and the ROB.
// PARAMETERS
//  NUM_SRC    4                       number of FU write-back sources
//  BUF_DEPTH  2                       entries per source buffer (power of 2, >=2)
//  PTR_W      `HiCore_ROB_PTR_SIZE    ROB pointer width
//  WB_W       `HiCore_WB_SIZE         write-back payload width
// PORTS
//  clk          in   1              core clock
//  rst_n        in   1              asynchronous reset, active low
//  src_wb_wen   in   NUM_SRC        per-source write-back valid (one-cycle pulse, no ready)
//  src_wb_ptr   in   NUM_SRC*PTR_W  ROB pointer, source i at [i*PTR_W +: PTR_W]
//  src_wb_info  in   NUM_SRC*WB_W   payload, source i at [i*WB_W +: WB_W]
//  src_wb_stall out  NUM_SRC        registered; 1 = source's buffer count >= BUF_DEPTH-1, issue must hold ready low
//  rob_wb_wen   out  1              registered ROB write enable
//  rob_wb_ptr   out  PTR_W          registered ROB pointer
//  rob_wb_info  out  WB_W           registered payload
//  flush        in   1              pipeline flush
// BEHAVIOUR
//  - Reset (rst_n low, async): all buffers empty, rr pointer = 0, rob_wb_wen = 0, rob_wb_ptr/info = 0, src_wb_stall = 0.
//  - Per-source buffer: in-order FIFO; write on src_wb_wen[i] & ~flush; read when source i granted.
//  - Eligible(i) = buffer i non-empty (or bypass candidate, see CONFIGURATION). Grant = first eligible at or after
//    rr pointer, wrapping modulo NUM_SRC. On grant, rr pointer <= grant+1 (wraps NUM_SRC-1 -> 0); no grant -> unchanged.
//  - One grant per cycle; granted entry loaded into output reg, rob_wb_wen=1 next cycle; no grant -> rob_wb_wen=0.
//  - Simultaneous write and read on same buffer allowed at any count, incl. full (count unchanged).
//  - Write to a full buffer with no read = overflow: entry dropped, simulation assertion fires (protocol error).
//  - stall threshold BUF_DEPTH-1 leaves one slot of slack for an op already issued in the same cycle.
//  - flush: same cycle all buffers cleared, incoming wen ignored; next cycle rob_wb_wen=0, stall=0; rr pointer kept.
//  - Pointer wrap: buffer rd/wr pointers carry an extra wrap bit; full = ptrs equal except wrap bit.
//  - Reset asserted mid-operation: immediate return to reset state; in-flight entries lost.
// CONFIGURATION
//  HICORE_WB_BYPASS_EN defined: source with empty buffer and src_wb_wen=1 is eligible that cycle; if granted, payload
//    goes straight to output reg (not written to buffer) -> wen-to-rob_wb_wen latency 1 cycle.
//  Not defined: every result is written to its buffer first; earliest grant next cycle -> latency 2 cycles.
//  Ordering per source is preserved in both modes (bypass only when buffer empty).
// STRUCTURE
//  - config.v: HiCore_ROB_PTR_SIZE, HiCore_WB_SIZE, new HiCore_WB_SRC_NUM (default 4); source index defines
//    HiCore_WB_SRC_NOP=0, _ALU=1, _LSU=2, _MDU=3.
//  - Sub-module hicore_wb_fifo: one per source (generate loop); params DEPTH, WIDTH=PTR_W+WB_W; ports clk, rst_n,
//    wr_en, wr_data, rd_en, rd_data, empty, full, count, clear.
//  - Top: round-robin grant, output reg, stall regs.
// TESTING
//  1 Reset: rst_n=0 mid-traffic -> rob_wb_wen=0, stall=0 same cycle; first wen on src0 ptr=5 after release -> rob out ptr=5.
//  2 Round-robin: all 4 sources pulse wen once (ptrs 1,2,3,4), rr=0 -> rob ptr order 1,2,3,4 on consecutive cycles.
//  3 Fairness: src0 pulses every cycle, src2 once (ptr=9) -> ptr 9 appears within 2 grants; src0 never starved.
//  4 Full/stall (BUF_DEPTH=2): src1 two back-to-back wens while src0 continuously granted -> src_wb_stall[1]=1
//    after first write; third wen while full triggers overflow assertion.
//  5 Flush: buffers hold 3 entries, flush=1 with src3 wen same cycle -> next cycle rob_wb_wen=0, nothing ever emitted.
//  6 Latency: single src0 wen ptr=7 into idle arbiter -> rob_wb_wen at +1 with HICORE_WB_BYPASS_EN, +2 without.

Source files
------------

// File: rtl/hicore_wb_arbiter_pkg.sv
// Shared constants for the HiCore write-back arbiter: ROB/payload widths, source count and source indices.
package hicore_wb_arbiter_pkg;

  localparam int HICORE_ROB_PTR_SIZE = 6;
  localparam int HICORE_WB_SIZE      = 32;
  localparam int HICORE_WB_SRC_NUM   = 4;

  typedef enum logic [1:0] {
    WB_SRC_NOP = 2'd0,
    WB_SRC_ALU = 2'd1,
    WB_SRC_LSU = 2'd2,
    WB_SRC_MDU = 2'd3
  } wb_src_e;

  // Round-robin successor of a granted index, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/hicore_wb_fifo.sv
// Per-source write-back buffer: in-order FIFO with wrap-bit pointers and a synchronous clear.
module hicore_wb_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count,
  input  logic             clear
);

  logic [AW:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic                       wr_ok, rd_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // A read in the same cycle frees the head slot, so a full buffer may still accept.
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(wr_ok);
    rd_ptr_d = rd_ptr_q + (AW+1)'(rd_ok);
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !clear) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(wr_en && full && !rd_en && !clear));
`endif

endmodule

// File: rtl/hicore_wb_arbiter.sv
// Round-robin merge of NUM_SRC FU write-back streams onto the registered ROB write-back port.
// Define HICORE_WB_BYPASS_EN to let an empty-buffer source go straight to the output register.
module hicore_wb_arbiter
  import hicore_wb_arbiter_pkg::*;
#(
  parameter int NUM_SRC   = HICORE_WB_SRC_NUM,
  parameter int BUF_DEPTH = 2,
  parameter int PTR_W     = HICORE_ROB_PTR_SIZE,
  parameter int WB_W      = HICORE_WB_SIZE
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SRC-1:0]       src_wb_wen,
  input  logic [NUM_SRC*PTR_W-1:0] src_wb_ptr,
  input  logic [NUM_SRC*WB_W-1:0]  src_wb_info,
  output logic [NUM_SRC-1:0]       src_wb_stall,
  output logic                     rob_wb_wen,
  output logic [PTR_W-1:0]         rob_wb_ptr,
  output logic [WB_W-1:0]          rob_wb_info,
  input  logic                     flush
);

  localparam int ENT_W = PTR_W + WB_W;
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0][ENT_W-1:0] in_ent, head_ent;
  logic [NUM_SRC-1:0][CNT_W-1:0] cnt;
  logic [NUM_SRC-1:0]            empty, full, fifo_wr, fifo_rd, byp_cand, elig, gnt_oh, stall_d;
  logic [NUM_SRC-1:0]            stall_q;
  logic [SRC_W-1:0]              rr_q, rr_d, gnt_idx;
  logic                          gnt_vld;
  logic [ENT_W-1:0]              sel_ent;
  logic                          rob_wen_q;
  logic [PTR_W-1:0]              rob_ptr_q;
  logic [WB_W-1:0]               rob_info_q;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic             wr_acc;
    logic [CNT_W-1:0] cnt_nxt;

    assign in_ent[i] = {src_wb_ptr[i*PTR_W +: PTR_W], src_wb_info[i*WB_W +: WB_W]};
`ifdef HICORE_WB_BYPASS_EN
    // Bypass only from an empty buffer so per-source order is kept.
    assign byp_cand[i] = empty[i] & src_wb_wen[i];
`else
    assign byp_cand[i] = 1'b0;
`endif
    assign elig[i]    = ~flush & (~empty[i] | byp_cand[i]);
    assign fifo_rd[i] = gnt_oh[i] & ~empty[i];
    assign fifo_wr[i] = src_wb_wen[i] & ~flush & ~(gnt_oh[i] & byp_cand[i]);

    // Stall tracks the post-update occupancy; threshold DEPTH-1 leaves one slot for an op already in flight.
    assign wr_acc     = fifo_wr[i] & (~full[i] | fifo_rd[i]);
    assign cnt_nxt    = cnt[i] + CNT_W'(wr_acc) - CNT_W'(fifo_rd[i]);
    assign stall_d[i] = ~flush & (cnt_nxt >= CNT_W'(BUF_DEPTH - 1));

    hicore_wb_fifo #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (ENT_W)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (fifo_wr[i]),
      .wr_data (in_ent[i]),
      .rd_en   (fifo_rd[i]),
      .rd_data (head_ent[i]),
      .empty   (empty[i]),
      .full    (full[i]),
      .count   (cnt[i]),
      .clear   (flush)
    );
  end

  // Scan from farthest to nearest so the first eligible source at/after rr_q wins.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = SRC_W'(idx);
      end
    end
  end

  assign gnt_oh  = gnt_vld ? (NUM_SRC'(1) << gnt_idx) : '0;
  assign sel_ent = byp_cand[gnt_idx] ? in_ent[gnt_idx] : head_ent[gnt_idx];
  assign rr_d    = gnt_vld ? SRC_W'(rr_next(int'(gnt_idx), NUM_SRC)) : rr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q       <= '0;
      rob_wen_q  <= 1'b0;
      rob_ptr_q  <= '0;
      rob_info_q <= '0;
      stall_q    <= '0;
    end else begin
      rr_q      <= rr_d;
      rob_wen_q <= gnt_vld;
      stall_q   <= stall_d;
      if (gnt_vld) {rob_ptr_q, rob_info_q} <= sel_ent;
    end
  end

  assign rob_wb_wen   = rob_wen_q;
  assign rob_wb_ptr   = rob_ptr_q;
  assign rob_wb_info  = rob_info_q;
  assign src_wb_stall = stall_q;

endmodule

// File: tb/tb_hicore_wb_arbiter.sv
// Bench for hicore_wb_arbiter: directed scenarios plus random traffic against a queue-based reference model.
module tb_hicore_wb_arbiter;
  import hicore_wb_arbiter_pkg::*;

  localparam int N  = HICORE_WB_SRC_NUM;
  localparam int D  = 2;
  localparam int PW = HICORE_ROB_PTR_SIZE;
  localparam int IW = HICORE_WB_SIZE;
`ifdef HICORE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic [N-1:0]    src_wb_wen = '0;
  logic [N*PW-1:0] src_wb_ptr = '0;
  logic [N*IW-1:0] src_wb_info = '0;
  logic [N-1:0]    src_wb_stall;
  logic            rob_wb_wen;
  logic [PW-1:0]   rob_wb_ptr;
  logic [IW-1:0]   rob_wb_info;

  always #5 clk = ~clk;

  hicore_wb_arbiter #(.NUM_SRC(N), .BUF_DEPTH(D), .PTR_W(PW), .WB_W(IW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .src_wb_wen   (src_wb_wen),
    .src_wb_ptr   (src_wb_ptr),
    .src_wb_info  (src_wb_info),
    .src_wb_stall (src_wb_stall),
    .rob_wb_wen   (rob_wb_wen),
    .rob_wb_ptr   (rob_wb_ptr),
    .rob_wb_info  (rob_wb_info),
    .flush        (flush)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference model: one queue per source, a rotating priority start and the expected next-cycle outputs.
  logic [PW-1:0] qp [N][$];
  logic [IW-1:0] qi [N][$];
  int            rr;
  logic          exp_wen;
  logic [PW-1:0] exp_ptr;
  logic [IW-1:0] exp_info;
  logic [N-1:0]  exp_stall;
  logic [PW-1:0] dp [N];
  logic [IW-1:0] di [N];
  logic [PW-1:0] emit_q[$];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      qp[i].delete();
      qi[i].delete();
    end
    rr = 0; exp_wen = 1'b0; exp_ptr = '0; exp_info = '0; exp_stall = '0;
  endtask

  task automatic model_step(input logic [N-1:0] w, input logic fl);
    int  g;
    bit  byp_used;
    g = -1;
    byp_used = 1'b0;
    if (fl) begin
      for (int i = 0; i < N; i++) begin
        qp[i].delete();
        qi[i].delete();
      end
      exp_wen   = 1'b0;
      exp_stall = '0;
      return;
    end
    for (int k = 0; k < N; k++) begin
      int i;
      i = (rr + k) % N;
      if (g < 0 && (qp[i].size() > 0 || (BYP && w[i]))) g = i;
    end
    exp_wen = (g >= 0);
    if (g >= 0) begin
      if (qp[g].size() > 0) begin
        exp_ptr  = qp[g].pop_front();
        exp_info = qi[g].pop_front();
      end else begin
        exp_ptr  = dp[g];
        exp_info = di[g];
        byp_used = 1'b1;
      end
      rr = (g + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      if (w[i] && !(byp_used && i == g) && qp[i].size() < D) begin
        qp[i].push_back(dp[i]);
        qi[i].push_back(di[i]);
      end
      exp_stall[i] = (qp[i].size() >= D - 1);
    end
  endtask

  // Called at posedge+1; drives one cycle of inputs, then checks outputs just after the next edge.
  task automatic step(input logic [N-1:0] w, input logic fl);
    src_wb_wen = w;
    flush      = fl;
    for (int i = 0; i < N; i++) begin
      src_wb_ptr[i*PW +: PW]  = dp[i];
      src_wb_info[i*IW +: IW] = di[i];
    end
    model_step(w, fl);
    @(posedge clk);
    #1;
    chk("rob_wen", rob_wb_wen, exp_wen);
    if (exp_wen) begin
      chk("rob_ptr", rob_wb_ptr, exp_ptr);
      chk("rob_info", rob_wb_info, exp_info);
    end
    chk("stall", src_wb_stall, exp_stall);
    if (rob_wb_wen) emit_q.push_back(rob_wb_ptr);
    src_wb_wen = '0;
    flush      = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step('0, 1'b0);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wen", rob_wb_wen, 1'b0);
    chk("rst_stall", src_wb_stall, '0);
    chk("rst_ptr", rob_wb_ptr, '0);
    chk("rst_info", rob_wb_info, '0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic rand_step(input int flush_odds);
    logic [N-1:0] w;
    w = '0;
    for (int i = 0; i < N; i++) begin
      dp[i] = PW'($urandom);
      di[i] = IW'($urandom);
      if (qp[i].size() < D && $urandom_range(0, 9) < 4) w[i] = 1'b1;
    end
    step(w, (flush_odds > 0) && ($urandom_range(0, flush_odds - 1) == 0));
  endtask

  initial begin
    int n0, src0_cnt, nine_cnt;
    model_reset();
    @(posedge clk);
    #1;
    chk("init_wen", rob_wb_wen, 1'b0);
    chk("init_stall", src_wb_stall, '0);
    rst_n = 1'b1;

    // Latency from a single write into an idle arbiter.
    dp[0] = PW'(7); di[0] = IW'(32'h0000_ABCD);
    n0 = emit_q.size();
    step(4'b0001, 1'b0);
    chk("lat_cyc1", emit_q.size() - n0, BYP ? 1 : 0);
    step('0, 1'b0);
    chk("lat_cyc2", emit_q.size() - n0, 1);
    chk("lat_ptr", emit_q[n0], 7);
    idle(2);

    // Round robin from rr=0 with all sources at once.
    do_reset();
    emit_q.delete();
    for (int i = 0; i < N; i++) begin
      dp[i] = PW'(i + 1);
      di[i] = IW'($urandom);
    end
    step('1, 1'b0);
    idle(5);
    chk("rr_count", emit_q.size(), N);
    for (int k = 0; k < N && k < emit_q.size(); k++) chk("rr_order", emit_q[k], k + 1);

    // Fairness: src0 writes whenever it has room, src2 once with ptr 9.
    emit_q.delete();
    for (int c = 0; c < 12; c++) begin
      logic [N-1:0] w;
      w = '0;
      dp[0] = PW'(20 + c); di[0] = IW'($urandom);
      if (qp[0].size() < D) w[0] = 1'b1;
      if (c == 1) begin
        dp[int'(WB_SRC_LSU)] = PW'(9);
        w[int'(WB_SRC_LSU)] = 1'b1;
      end
      step(w, 1'b0);
    end
    idle(4);
    src0_cnt = 0; nine_cnt = 0;
    foreach (emit_q[k]) begin
      if (emit_q[k] == PW'(9)) nine_cnt++;
      else if (emit_q[k] >= PW'(20)) src0_cnt++;
    end
    chk("fair_ptr9", nine_cnt, 1);
    chk("fair_src0_served", src0_cnt >= 8, 1'b1);
    chk("fair_ptr9_early", (emit_q.size() > 4) && (emit_q[0] == PW'(9) || emit_q[1] == PW'(9) ||
                            emit_q[2] == PW'(9) || emit_q[3] == PW'(9)), 1'b1);

    // Back-to-back writes on src1 while src0 keeps the arbiter busy; stall followed by the model.
    for (int c = 0; c < 6; c++) begin
      logic [N-1:0] w;
      w = '0;
      dp[0] = PW'($urandom); dp[1] = PW'(40 + c);
      if (qp[0].size() < D) w[0] = 1'b1;
      if (c < 2) w[1] = 1'b1;
      step(w, 1'b0);
    end
    idle(4);

    // Flush with entries buffered and a same-cycle write from src3.
    step(4'b1110, 1'b0);
    emit_q.delete();
    dp[int'(WB_SRC_MDU)] = PW'(33);
    step(4'b1000, 1'b1);
    idle(5);
    chk("flush_emit", emit_q.size(), 0);

    // Reset in the middle of traffic, then a fresh write on src0.
    for (int c = 0; c < 5; c++) rand_step(0);
    do_reset();
    emit_q.delete();
    dp[0] = PW'(5); di[0] = IW'($urandom);
    step(4'b0001, 1'b0);
    idle(3);
    chk("post_rst_count", emit_q.size(), 1);
    if (emit_q.size() > 0) chk("post_rst_ptr", emit_q[0], 5);

    for (int c = 0; c < 3000; c++) rand_step(32);
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
